// File: rtl/video_tx_timing_gen_pkg.sv
// Shared 1080p30 timing constants, TX FSM state type and colour-bar palette
// for the video_tx_timing_gen slice.
package video_tx_timing_gen_pkg;

  localparam int TIMING_TOTAL_X      = 2200;
  localparam int TIMING_TOTAL_Y      = 1125;
  localparam int TIMING_ACTIVE_X     = 1920;
  localparam int TIMING_H_FRONT      = 88;
  localparam int TIMING_HSYNC_WIDTH  = 44;
  localparam int TIMING_ACTIVE_LINES = 1080;
  localparam int TIMING_V_FRONT      = 4;
  localparam int TIMING_VSYNC_WIDTH  = 5;

  typedef enum logic {
    SEEK_SOF = 1'b0,
    RUN      = 1'b1
  } tx_state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Free-running x/y raster counters with active, hsync and vsync decode.
// Never stalls: timing is independent of the pixel stream.
module video_timing_cnt
  import video_tx_timing_gen_pkg::*;
#(
  parameter int TOTAL_X      = TIMING_TOTAL_X,
  parameter int TOTAL_Y      = TIMING_TOTAL_Y,
  parameter int ACTIVE_X     = TIMING_ACTIVE_X,
  parameter int H_FRONT      = TIMING_H_FRONT,
  parameter int HSYNC_WIDTH  = TIMING_HSYNC_WIDTH,
  parameter int ACTIVE_LINES = TIMING_ACTIVE_LINES,
  parameter int V_FRONT      = TIMING_V_FRONT,
  parameter int VSYNC_WIDTH  = TIMING_VSYNC_WIDTH,
  parameter int XW           = $clog2(TOTAL_X),
  parameter int YW           = $clog2(TOTAL_Y)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          hsync,
  output logic          vsync
);

  localparam int HS_FIRST = ACTIVE_X + H_FRONT;
  localparam int HS_LAST  = HS_FIRST + HSYNC_WIDTH - 1;
  localparam int VS_FIRST = ACTIVE_LINES + V_FRONT;
  localparam int VS_LAST  = VS_FIRST + VSYNC_WIDTH - 1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x <= '0;
      y <= '0;
    end else if (x == XW'(TOTAL_X - 1)) begin
      x <= '0;
      y <= (y == YW'(TOTAL_Y - 1)) ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  assign active = (x < XW'(ACTIVE_X)) && (y < YW'(ACTIVE_LINES));
  assign hsync  = (x >= XW'(HS_FIRST)) && (x <= XW'(HS_LAST));
  assign vsync  = (y >= YW'(VS_FIRST)) && (y <= YW'(VS_LAST));

endmodule

// File: rtl/video_tx_timing_gen.sv
// AXI4-Stream to parallel RGB video transmitter with SOF/EOL resync.
// Optional colour-bar generator enabled by defining VIDEO_TX_COLOR_BARS_EN.
module video_tx_timing_gen
  import video_tx_timing_gen_pkg::*;
#(
  parameter int TOTAL_X                     = TIMING_TOTAL_X,
  parameter int TOTAL_Y                     = TIMING_TOTAL_Y,
  parameter int ACTIVE_X                    = TIMING_ACTIVE_X,
  parameter int DE_NEGEDGE_TO_HSYNC_POSEDGE = TIMING_H_FRONT,
  parameter int HSYNC_WIDTH                 = TIMING_HSYNC_WIDTH,
  parameter int ACTIVE_LINES                = TIMING_ACTIVE_LINES,
  parameter int VERTICAL_BLANKING_POST      = TIMING_V_FRONT,
  parameter int VSYNC_WIDTH                 = TIMING_VSYNC_WIDTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef VIDEO_TX_COLOR_BARS_EN
  input  logic        pattern_en_i,
`endif
  input  logic [23:0] video_tdata_i,
  input  logic        video_tvalid_i,
  output logic        video_tready_o,
  input  logic        video_tuser_i,
  input  logic        video_tlast_i,
  output logic [23:0] rgb_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        underflow_o
);

  localparam int XW = $clog2(TOTAL_X);
  localparam int YW = $clog2(TOTAL_Y);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active, hsync, vsync;

  video_timing_cnt #(
    .TOTAL_X     (TOTAL_X),
    .TOTAL_Y     (TOTAL_Y),
    .ACTIVE_X    (ACTIVE_X),
    .H_FRONT     (DE_NEGEDGE_TO_HSYNC_POSEDGE),
    .HSYNC_WIDTH (HSYNC_WIDTH),
    .ACTIVE_LINES(ACTIVE_LINES),
    .V_FRONT     (VERTICAL_BLANKING_POST),
    .VSYNC_WIDTH (VSYNC_WIDTH),
    .XW          (XW),
    .YW          (YW)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .x     (x),
    .y     (y),
    .active(active),
    .hsync (hsync),
    .vsync (vsync)
  );

  tx_state_e   state, state_n;
  logic        tready_c, underflow_n;
  logic [23:0] rgb_n;
  logic        origin, last_x, sof_at_origin, run_now;

  assign origin        = (x == '0) && (y == '0);
  assign last_x        = (x == XW'(ACTIVE_X - 1));
  // A held SOF at the origin is consumed in the same cycle the FSM locks.
  assign sof_at_origin = video_tvalid_i && video_tuser_i && origin;
  assign run_now       = (state == RUN) || sof_at_origin;

`ifdef VIDEO_TX_COLOR_BARS_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'(x / XW'(ACTIVE_X / 8));
`endif

  // NOTE: every combinational output gets a default first, so no path
  // through the if/else tree can infer a latch.
  always_comb begin
    state_n     = state;
    tready_c    = 1'b0;
    rgb_n       = '0;
    underflow_n = 1'b0;

    if (!run_now) begin
      // Discard beats until SOF, then hold the SOF beat.
      tready_c = video_tvalid_i && !video_tuser_i;
    end else begin
      state_n = RUN;
      if (active) begin
        if (!video_tvalid_i) begin
          tready_c    = 1'b1;
          underflow_n = 1'b1;
          state_n     = SEEK_SOF;
        end else if (video_tuser_i && !origin) begin
          underflow_n = 1'b1;
          state_n     = SEEK_SOF;
        end else begin
          tready_c = 1'b1;
          rgb_n    = video_tdata_i;
          if ((!video_tuser_i && origin) || (video_tlast_i != last_x)) begin
            underflow_n = 1'b1;
            state_n     = SEEK_SOF;
          end
        end
      end
    end

`ifdef VIDEO_TX_COLOR_BARS_EN
    if (pattern_en_i) begin
      tready_c    = 1'b1;
      underflow_n = 1'b0;
      state_n     = SEEK_SOF;
      rgb_n       = active ? bar_color(bar_idx) : '0;
    end
`endif
  end

  // Ready is combinational; force it low while reset is held.
  assign video_tready_o = tready_c && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= SEEK_SOF;
      rgb_o       <= '0;
      de_o        <= 1'b0;
      hsync_o     <= 1'b0;
      vsync_o     <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state       <= state_n;
      rgb_o       <= rgb_n;
      de_o        <= active;
      hsync_o     <= hsync;
      vsync_o     <= vsync;
      underflow_o <= underflow_n;
    end
  end

endmodule

// File: tb/tb_video_tx_timing_gen.sv
// Directed bench for video_tx_timing_gen using a reduced raster so full
// frames fit in a short run; expectations come from a bench-side model.
module tb_video_tx_timing_gen;

  localparam int AX   = 16;
  localparam int FP   = 4;
  localparam int HW   = 6;
  localparam int TX   = 32;
  localparam int AL   = 8;
  localparam int VP   = 2;
  localparam int VW   = 2;
  localparam int TY   = 12;
  localparam int FPIX = AX * AL;
  localparam int FCYC = TX * TY;

  localparam int DROP_X = 10;
  localparam int DROP_Y = 3;
  localparam int SKIP_B = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] tdata  = '0;
  logic        tvalid = 1'b0;
  logic        tuser  = 1'b0;
  logic        tlast  = 1'b0;
  logic        tready;
  logic [23:0] rgb;
  logic        de, hs, vs, uf;
`ifdef VIDEO_TX_COLOR_BARS_EN
  logic        pattern_en = 1'b0;
`endif

  video_tx_timing_gen #(
    .TOTAL_X                    (TX),
    .TOTAL_Y                    (TY),
    .ACTIVE_X                   (AX),
    .DE_NEGEDGE_TO_HSYNC_POSEDGE(FP),
    .HSYNC_WIDTH                (HW),
    .ACTIVE_LINES               (AL),
    .VERTICAL_BLANKING_POST     (VP),
    .VSYNC_WIDTH                (VW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
`ifdef VIDEO_TX_COLOR_BARS_EN
    .pattern_en_i  (pattern_en),
`endif
    .video_tdata_i (tdata),
    .video_tvalid_i(tvalid),
    .video_tready_o(tready),
    .video_tuser_i (tuser),
    .video_tlast_i (tlast),
    .rgb_o         (rgb),
    .de_o          (de),
    .hsync_o       (hs),
    .vsync_o       (vs),
    .underflow_o   (uf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model raster position (next edge), position of the last sampled edge,
  // source frame/beat, and scenario controls.
  int   ex, ey, mf, px, py, pf, sf, sb, acc_cnt;
  bit   src_en, drop_en, skip_en;
  logic rdy, acc;

  function automatic bit m_act(int x, int y);
    return (x < AX) && (y < AL);
  endfunction

  function automatic bit m_hs(int x);
    return (x >= AX + FP) && (x < AX + FP + HW);
  endfunction

  function automatic bit m_vs(int y);
    return (y >= AL + VP) && (y < AL + VP + VW);
  endfunction

  function automatic logic [23:0] pix(int f, int b);
    logic [7:0] fb, bb;
    fb = 8'(16 + f);
    bb = 8'(b);
    return {fb, bb, ~bb};
  endfunction

  task automatic cycle();
    @(negedge clk);
    tdata  = pix(sf, sb);
    tuser  = (sb == 0);
    tlast  = ((sb % AX) == AX - 1);
    tvalid = src_en && !(drop_en && mf == 0 && ex == DROP_X && ey == DROP_Y);
    #1;
    rdy = tready;
    acc = tvalid && tready;
    px = ex; py = ey; pf = mf;
    @(posedge clk);
    #1;
    if (acc) begin
      acc_cnt++;
      sb++;
      if (sb == FPIX) begin sb = 0; sf++; end
      if (skip_en && sf == 0 && sb == SKIP_B) begin sf = 1; sb = 0; end
    end
    if (ex == TX - 1) begin
      ex = 0;
      if (ey == TY - 1) begin ey = 0; mf++; end
      else ey++;
    end else begin
      ex++;
    end
  endtask

  // Leaves the bench just after a clock edge with reset released, so the
  // next edge is the first one at raster position (0,0).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    src_en = 0; drop_en = 0; skip_en = 0;
    tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ex = 0; ey = 0; mf = 0; sf = 0; sb = 0; acc_cnt = 0;
  endtask

  task automatic test_reset();
    logic [28:0] got;
    tvalid = 1'b1; tuser = 1'b0; tdata = 24'hFFFFFF;
    rst = 1'b1;
    #12;
    got = {rgb, de, hs, vs, uf, tready};
    vectors++;
    if (got !== 29'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0", got);
    end
    repeat (2) @(posedge clk);
    #1;
    got = {rgb, de, hs, vs, uf, tready};
    vectors++;
    if (got !== 29'h0) begin
      miscompares++;
      $display("FAIL reset_held: got %h expected 0", got);
    end
  endtask

  task automatic test_free_run();
    logic [27:0] got, exp;
    int   de_cnt, hs_cnt, vs_cnt;
    logic prev_hs;
    do_reset();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; prev_hs = 1'b0;
    for (int i = 0; i < 2 * FCYC; i++) begin
      cycle();
      got = {rgb, de, hs, vs, uf};
      exp = {24'h0, m_act(px, py), m_hs(px), m_vs(py), 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL free_run (%0d,%0d): got %h expected %h", px, py, got, exp);
      end
      if (hs && !prev_hs) begin
        vectors++;
        if (px != AX + FP) begin
          miscompares++;
          $display("FAIL hsync_rise_x: got %0d expected %0d", px, AX + FP);
        end
      end
      prev_hs = hs;
      de_cnt += int'(de); hs_cnt += int'(hs); vs_cnt += int'(vs);
    end
    vectors++;
    if (de_cnt != 2 * FPIX) begin
      miscompares++;
      $display("FAIL de_count: got %0d expected %0d", de_cnt, 2 * FPIX);
    end
    vectors++;
    if (hs_cnt != 2 * HW * TY) begin
      miscompares++;
      $display("FAIL hsync_count: got %0d expected %0d", hs_cnt, 2 * HW * TY);
    end
    vectors++;
    if (vs_cnt != 2 * VW * TX) begin
      miscompares++;
      $display("FAIL vsync_count: got %0d expected %0d", vs_cnt, 2 * VW * TX);
    end
  endtask

  task automatic test_full_frame();
    logic [27:0] got, exp;
    logic [23:0] e_rgb;
    do_reset();
    src_en = 1;
    for (int i = 0; i < 2 * FCYC; i++) begin
      cycle();
      e_rgb = m_act(px, py) ? pix(pf, py * AX + px) : 24'h0;
      got = {rgb, de, hs, vs, uf};
      exp = {e_rgb, m_act(px, py), m_hs(px), m_vs(py), 1'b0};
      vectors++;
      if (got !== exp || rdy !== m_act(px, py)) begin
        miscompares++;
        $display("FAIL full_frame (%0d,%0d) f%0d: got %h rdy %b expected %h rdy %b",
                 px, py, pf, got, rdy, exp, m_act(px, py));
      end
    end
    vectors++;
    if (acc_cnt != 2 * FPIX) begin
      miscompares++;
      $display("FAIL beats_consumed: got %0d expected %0d", acc_cnt, 2 * FPIX);
    end
  endtask

  task automatic test_underflow();
    logic [27:0] got, exp;
    logic [23:0] e_rgb;
    bit          shown, e_uf;
    int          uf_cnt;
    do_reset();
    src_en = 1; drop_en = 1; uf_cnt = 0;
    for (int i = 0; i < 2 * FCYC; i++) begin
      cycle();
      shown = (pf == 1) || (pf == 0 && (py * AX + px) < (DROP_Y * AX + DROP_X));
      e_rgb = (m_act(px, py) && shown) ? pix(pf, py * AX + px) : 24'h0;
      e_uf  = (pf == 0 && px == DROP_X && py == DROP_Y);
      got = {rgb, de, hs, vs, uf};
      exp = {e_rgb, m_act(px, py), m_hs(px), m_vs(py), e_uf};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL underflow (%0d,%0d) f%0d: got %h expected %h", px, py, pf, got, exp);
      end
      uf_cnt += int'(uf);
    end
    vectors++;
    if (uf_cnt != 1) begin
      miscompares++;
      $display("FAIL underflow_pulses: got %0d expected 1", uf_cnt);
    end
  endtask

  task automatic test_early_sof();
    logic [27:0] got, exp;
    logic [23:0] e_rgb;
    bit          shown, at_err;
    do_reset();
    src_en = 1; skip_en = 1;
    for (int i = 0; i < 2 * FCYC; i++) begin
      cycle();
      at_err = (pf == 0 && px == SKIP_B && py == 0);
      shown  = (pf == 1) || (pf == 0 && py == 0 && px < SKIP_B);
      e_rgb  = (m_act(px, py) && shown) ? pix(pf, py * AX + px) : 24'h0;
      got = {rgb, de, hs, vs, uf};
      exp = {e_rgb, m_act(px, py), m_hs(px), m_vs(py), at_err};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL early_sof (%0d,%0d) f%0d: got %h expected %h", px, py, pf, got, exp);
      end
      if (at_err) begin
        vectors++;
        if (rdy !== 1'b0) begin
          miscompares++;
          $display("FAIL early_sof_hold: tready %b expected 0", rdy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [28:0] got;
    logic [27:0] g2, exp;
    logic [23:0] e_rgb;
    do_reset();
    src_en = 1;
    for (int i = 0; i < FCYC && !(ex == 12 && ey == 5); i++) cycle();
    #1;
    rst = 1'b1;
    #1;
    got = {rgb, de, hs, vs, uf, tready};
    vectors++;
    if (got !== 29'h0) begin
      miscompares++;
      $display("FAIL reset_mid_immediate: got %h expected 0", got);
    end
    repeat (3) @(posedge clk);
    #1;
    got = {rgb, de, hs, vs, uf, tready};
    vectors++;
    if (got !== 29'h0) begin
      miscompares++;
      $display("FAIL reset_mid_held: got %h expected 0", got);
    end
    rst = 1'b0;
    ex = 0; ey = 0; mf = 0; sf = 0; sb = 0; acc_cnt = 0;
    for (int i = 0; i < FCYC; i++) begin
      cycle();
      e_rgb = m_act(px, py) ? pix(pf, py * AX + px) : 24'h0;
      g2  = {rgb, de, hs, vs, uf};
      exp = {e_rgb, m_act(px, py), m_hs(px), m_vs(py), 1'b0};
      vectors++;
      if (g2 !== exp) begin
        miscompares++;
        $display("FAIL reset_restart (%0d,%0d): got %h expected %h", px, py, g2, exp);
      end
    end
  endtask

`ifdef VIDEO_TX_COLOR_BARS_EN
  function automatic logic [23:0] m_bar(int x);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[x / (AX / 8)];
  endfunction

  task automatic test_color_bars();
    logic [27:0] got, exp;
    logic [23:0] e_rgb;
    do_reset();
    pattern_en = 1'b1;
    src_en = 1;
    for (int i = 0; i < FCYC; i++) begin
      cycle();
      e_rgb = m_act(px, py) ? m_bar(px) : 24'h0;
      got = {rgb, de, hs, vs, uf};
      exp = {e_rgb, m_act(px, py), m_hs(px), m_vs(py), 1'b0};
      vectors++;
      if (got !== exp || rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL color_bars (%0d,%0d): got %h rdy %b expected %h rdy 1",
                 px, py, got, rdy, exp);
      end
    end
    pattern_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_full_frame();
    test_underflow();
    test_early_sof();
    test_reset_mid();
`ifdef VIDEO_TX_COLOR_BARS_EN
    test_color_bars();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
